can_rx_buffer: RTL

// - Receive-side counterpart of the transmit buffer: collects one decoded CAN frame (ID, RTR, DLC, data

---
 rtl/can_rx_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/can_rx_buffer.sv
// can_rx_buffer: collects one decoded CAN frame from the bit-stream processor
// and queues complete, well-formed frames in a small frame FIFO. The host
// sees the oldest frame show-ahead on rd_* and pops it with rd_ack.
// Optional acceptance filter: define RX_ACCEPT_FILTER_EN to enable it.
module can_rx_buffer #(
  parameter int          FRAME_DEPTH = 4,
  parameter logic [10:0] ACC_CODE    = 11'h000,
  parameter logic [10:0] ACC_MASK    = 11'h7FF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rx_frame_start,
  input  logic [10:0]                    rx_id,
  input  logic                           rx_rtr,
  input  logic [3:0]                     rx_dlc,
  input  logic                           rx_byte_valid,
  input  logic [7:0]                     rx_byte,
  input  logic                           rx_frame_done,
  input  logic                           rx_frame_err,
  input  logic                           rd_ack,
  input  logic                           ovr_clr,
  output logic [10:0]                    rd_id,
  output logic                           rd_rtr,
  output logic [3:0]                     rd_dlc,
  output logic [63:0]                    rd_data,
  output logic                           rx_buff_busy,
  output logic                           rx_buff_empty,
  output logic                           rx_buff_full,
  output logic [$clog2(FRAME_DEPTH):0]   rx_frame_cnt,
  output logic                           rx_overrun,
  output logic                           rx_fmt_err
);

  localparam int PTR_W = $clog2(FRAME_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

  state_t             state;
  logic [10:0]        cur_id;
  logic               cur_rtr;
  logic [3:0]         cur_dlc;
  logic [3:0]         exp_n;
  logic [3:0]         byte_cnt;
  logic [63:0]        asm_data;

  logic [3:0]         hdr_n;
  logic               accept;
  logic               commit;
  logic               push;
  logic               pop;

  logic [10:0]        mem_id   [FRAME_DEPTH];
  logic               mem_rtr  [FRAME_DEPTH];
  logic [3:0]         mem_dlc  [FRAME_DEPTH];
  logic [63:0]        mem_data [FRAME_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  // Byte count implied by the incoming header; remote frames carry no data
  // and DLC values above 8 still mean 8 bytes.
  always_comb begin
    hdr_n = 4'd0;
    if (!rx_rtr) hdr_n = (rx_dlc > 4'd8) ? 4'd8 : rx_dlc;
  end

  // Acceptance decision taken on the header at rx_frame_start.
`ifdef RX_ACCEPT_FILTER_EN
  always_comb accept = (((rx_id ^ ACC_CODE) & ~ACC_MASK) == 11'd0);
`else
  // Every frame is accepted; the parameters are folded in only so they
  // stay referenced in this build.
  always_comb accept = 1'b1 | (|(ACC_CODE & ACC_MASK & rx_id));
`endif

  // A frame is committed only when it ends cleanly with the expected byte
  // count; an abort or a fresh header in the same cycle takes priority.
  always_comb begin
    commit = (state == COLLECT) && rx_frame_done && !rx_frame_err &&
             !rx_frame_start && (byte_cnt == exp_n);
  end

  // Collection state machine and the registered format-error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_fmt_err <= 1'b0;
    end else begin
      rx_fmt_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_frame_start) state <= accept ? COLLECT : DROP;
        end
        COLLECT: begin
          if (rx_frame_start) begin
            state <= accept ? COLLECT : DROP;
          end else if (rx_frame_err) begin
            state <= IDLE;
          end else if (rx_frame_done) begin
            state      <= IDLE;
            rx_fmt_err <= (byte_cnt != exp_n);
          end
        end
        DROP: begin
          if (rx_frame_start)                     state <= accept ? COLLECT : DROP;
          else if (rx_frame_done || rx_frame_err) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame assembly: header latch and byte packing, byte n at [8n+7:8n].
  always_ff @(posedge clk) begin
    if (rx_frame_start) begin
      cur_id   <= rx_id;
      cur_rtr  <= rx_rtr;
      cur_dlc  <= rx_dlc;
      exp_n    <= hdr_n;
      byte_cnt <= 4'd0;
      asm_data <= 64'd0;
    end else if ((state == COLLECT) && rx_byte_valid && (byte_cnt < 4'd8)) begin
      asm_data[{byte_cnt[2:0], 3'b000} +: 8] <= rx_byte;
      byte_cnt                               <= byte_cnt + 4'd1;
    end
  end

  assign rx_buff_busy  = (state == COLLECT);
  assign rx_buff_empty = (cnt == '0);
  assign rx_buff_full  = (cnt == CNT_W'(FRAME_DEPTH));
  assign rx_frame_cnt  = cnt;

  // A full FIFO still accepts a commit when the head is popped in the same
  // cycle; otherwise the committed frame is lost and flagged as overrun.
  always_comb begin
    pop  = rd_ack && !rx_buff_empty;
    push = commit && (!rx_buff_full || pop);
  end

  // Frame storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= cur_id;
      mem_rtr[wr_ptr]  <= cur_rtr;
      mem_dlc[wr_ptr]  <= cur_dlc;
      mem_data[wr_ptr] <= asm_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (commit && !push)  rx_overrun <= 1'b1;
      else if (ovr_clr)     rx_overrun <= 1'b0;
    end
  end

  // Show-ahead read port; all zero while nothing is stored.
  always_comb begin
    rd_id   = 11'd0;
    rd_rtr  = 1'b0;
    rd_dlc  = 4'd0;
    rd_data = 64'd0;
    if (!rx_buff_empty) begin
      rd_id   = mem_id[rd_ptr];
      rd_rtr  = mem_rtr[rd_ptr];
      rd_dlc  = mem_dlc[rd_ptr];
      rd_data = mem_data[rd_ptr];
    end
  end

endmodule
